clk_div_ctrl: RTL

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable clock divider with ratio handshake and glitch-free ratio changes
module clk_div_ctrl #(
  parameter int CNT_W    = 8,
  parameter int DIV_INIT = 4
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             en_i,
  input  logic             cfg_valid_i,
  input  logic [CNT_W-1:0] cfg_ratio_i,
  output logic             cfg_ready_o,
  output logic             cfg_err_o,
  output logic             clk_en_o,
  output logic             clk_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] ratio_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RATIO_RST = CNT_W'(DIV_INIT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE_W     = (CNT_W+1)'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ratio_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             err_d;
  logic             clk_d;

  logic             cfg_fire;
  logic             cfg_legal;
  logic             at_wrap;
  logic [CNT_W-1:0] cnt_step;
  logic [CNT_W:0]   half_d;

  // Handshake and period-boundary decode shared by the FSM and the outputs.
  assign cfg_ready_o = (state_q == IDLE) || (state_q == RUN);
  assign cfg_fire    = cfg_valid_i && cfg_ready_o;
  assign cfg_legal   = (cfg_ratio_i > ONE);
  assign at_wrap     = (cnt_q == (ratio_o - ONE));
  assign cnt_step    = at_wrap ? '0 : (cnt_q + ONE);
  assign busy_o      = (state_q != IDLE);
  assign clk_en_o    = busy_o && at_wrap;

  // Next-state, counter, ratio and shadow decisions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ratio_d  = ratio_o;
    shadow_d = shadow_q;
    err_d    = cfg_fire && !cfg_legal;

    case (state_q)
      IDLE: begin
        // Ratio is applied at the same edge that starts RUN, so the first
        // period already uses the new value.
        cnt_d = '0;
        if (cfg_fire && cfg_legal) begin
          ratio_d = cfg_ratio_i;
        end
        if (en_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_step;
        // A pending ratio takes priority over a stop request; PEND samples
        // en_i again at the wrap, so the stop request is not lost.
        if (cfg_fire && cfg_legal) begin
          shadow_d = cfg_ratio_i;
          state_d  = PEND;
        end else if (!en_i) begin
          state_d = STOP;
        end
      end
      PEND: begin
        cnt_d = cnt_step;
        if (at_wrap) begin
          ratio_d = shadow_q;
          state_d = en_i ? RUN : STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_step;
        if (en_i) begin
          state_d = RUN;
        end else if (at_wrap) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // clk_o is high for the first ceil(N/2) counts of every period and low
    // whenever the next cycle is IDLE.
    half_d = ({1'b0, ratio_d} + ONE_W) >> 1;
    clk_d  = (state_d != IDLE) && ({1'b0, cnt_d} < half_d);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ratio_o   <= RATIO_RST;
      shadow_q  <= RATIO_RST;
      clk_o     <= 1'b0;
      cfg_err_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ratio_o   <= ratio_d;
      shadow_q  <= shadow_d;
      clk_o     <= clk_d;
      cfg_err_o <= err_d;
    end
  end

endmodule
